// File: rtl/boot_copier_pkg.sv
// boot_copier_pkg: shared FSM state encoding and error codes for the boot image loader
package boot_copier_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FRD, S_RWR, S_CHK, S_DONE, S_ERR} state_e;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FLASH = 2'd1;
  localparam logic [1:0] ERR_RAM   = 2'd2;
  localparam logic [1:0] ERR_SUM   = 2'd3;
endpackage

// File: rtl/boot_copier_wdog.sv
// boot_copier_wdog: access watchdog, expires after TIMEOUT enabled cycles without a clear
module boot_copier_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + TW'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
  assign expire = en && cnt_q == TW'(TIMEOUT - 1);
endmodule

// File: rtl/boot_copier.sv
// boot_copier: flash-to-RAM image loader with checksum verify, whole-image retry and access timeout
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter int FLASH_AW   = 22,
  parameter int RAM_AW     = 18,
  parameter int DW         = 16,
  parameter int SRC_BASE   = 1,
  parameter int DST_BASE   = 0,
  parameter int WORDS      = 'h21A,
  parameter bit AUTO_START = 1'b1,
  parameter bit CHECK_EN   = 1'b1,
  parameter int MAX_RETRY  = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                flash_req,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic                flash_done,
  input  logic [DW-1:0]       flash_data,
  output logic                ram_req,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DW-1:0]       ram_data,
  input  logic                ram_done,
  output logic                boot_done,
  output logic                boot_err,
  output logic [1:0]          err_code,
  output logic [RAM_AW:0]     words_copied
);
  localparam int CW = RAM_AW + 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_e              state_q, state_d;
  logic [FLASH_AW-1:0] src_q, src_d;
  logic [RAM_AW-1:0]   dst_q, dst_d;
  logic [DW-1:0]       data_q, data_d, sum_q, sum_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [1:0]          err_q, err_d;
  logic                expire;
  // Timer restarts on every state change; accepted dones always change state
  boot_copier_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_d != state_q),
    .en     (state_q == S_FRD || state_q == S_RWR),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: state_d = (start || AUTO_START) ? S_FRD : S_IDLE;
      S_FRD:
        if (flash_done) begin
          data_d  = flash_data;
          sum_d   = sum_q + flash_data;
          state_d = S_RWR;
        end else if (expire) begin
          err_d   = ERR_FLASH;
          state_d = S_ERR;
        end
      S_RWR:
        if (ram_done) begin
          cnt_d   = cnt_q + CW'(1);
          src_d   = src_q + FLASH_AW'(1);
          dst_d   = dst_q + RAM_AW'(1);
          state_d = (cnt_q + CW'(1) == CW'(WORDS)) ? S_CHK : S_FRD;
        end else if (expire) begin
          err_d   = ERR_RAM;
          state_d = S_ERR;
        end
      S_CHK:
        if (!CHECK_EN || sum_q == '0) begin
          state_d = S_DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          src_d   = FLASH_AW'(SRC_BASE);
          dst_d   = RAM_AW'(DST_BASE);
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_FRD;
        end else begin
          err_d   = ERR_SUM;
          state_d = S_ERR;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= FLASH_AW'(SRC_BASE);
      dst_q   <= RAM_AW'(DST_BASE);
      data_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end
  assign flash_req    = state_q == S_FRD;
  assign ram_req      = state_q == S_RWR;
  assign flash_addr   = src_q;
  assign ram_addr     = dst_q;
  assign ram_data     = data_q;
  assign boot_done    = state_q == S_DONE;
  assign boot_err     = state_q == S_ERR;
  assign err_code     = err_q;
  assign words_copied = cnt_q;
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: directed bench with a transaction-level memory/image model checked every cycle
module tb_boot_copier;
  localparam int FAW = 22, RAW = 18, DW = 16, SRC = 1, DST = 0, W = 4, MR = 2, TO = 15;
  logic clk = 0, rst = 0, start = 0;
  always #5 clk = ~clk;
  logic sel = 0, active = 0, hang = 0, spur = 0;
  int mode = 0;
  logic fd = 0, rdn = 0;
  logic [DW-1:0] fdat = '0;
  logic f_req0, f_req1, r_req0, r_req1, bd0, bd1, be0, be1;
  logic [FAW-1:0] fa0, fa1;
  logic [RAW-1:0] ra0, ra1;
  logic [DW-1:0] rdat0, rdat1;
  logic [1:0] ec0, ec1;
  logic [RAW:0] wc0, wc1;
  logic f_req, r_req, bd, be;
  logic [FAW-1:0] fa;
  logic [RAW-1:0] ra;
  logic [DW-1:0] rdat;
  logic [1:0] ec;
  logic [RAW:0] wc;
  assign f_req = sel ? f_req1 : f_req0;
  assign r_req = sel ? r_req1 : r_req0;
  assign bd    = sel ? bd1 : bd0;
  assign be    = sel ? be1 : be0;
  assign fa    = sel ? fa1 : fa0;
  assign ra    = sel ? ra1 : ra0;
  assign rdat  = sel ? rdat1 : rdat0;
  assign ec    = sel ? ec1 : ec0;
  assign wc    = sel ? wc1 : wc0;
  boot_copier #(.FLASH_AW(FAW), .RAM_AW(RAW), .DW(DW), .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(W),
                .AUTO_START(1'b1), .CHECK_EN(1'b1), .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .flash_req(f_req0), .flash_addr(fa0),
    .flash_done(fd && !sel), .flash_data(fdat), .ram_req(r_req0), .ram_addr(ra0),
    .ram_data(rdat0), .ram_done(rdn && !sel), .boot_done(bd0), .boot_err(be0),
    .err_code(ec0), .words_copied(wc0));
  boot_copier #(.FLASH_AW(FAW), .RAM_AW(RAW), .DW(DW), .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(W),
                .AUTO_START(1'b0), .CHECK_EN(1'b1), .MAX_RETRY(MR), .TIMEOUT(TO)) dut_man (
    .clk(clk), .rst(rst), .start(start), .flash_req(f_req1), .flash_addr(fa1),
    .flash_done(fd && sel), .flash_data(fdat), .ram_req(r_req1), .ram_addr(ra1),
    .ram_data(rdat1), .ram_done(rdn && sel), .boot_done(bd1), .boot_err(be1),
    .err_code(ec1), .words_copied(wc1));
  int checks = 0, errors = 0;
  int rd_n = 0, wr_n = 0, cyc = 0, rise_cyc = 0, err_cyc = 0;
  bit prev_freq = 0, prev_err = 0;
  logic [DW-1:0] ram_mem [W];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Image {1,2,3,-6}; mode 1 corrupts the last word always, mode 2 only on pass 0
  function automatic logic [DW-1:0] img(int m, int p, int i);
    if (i < 3) return DW'(i + 1);
    return (m == 1 || (m == 2 && p == 0)) ? 16'hFFFB : 16'hFFFA;
  endfunction
  function automatic logic [DW-1:0] img_sum(int m, int p);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < W; i++) s += img(m, p, i);
    return s;
  endfunction
  function automatic int exp_passes(int m);
    for (int p = 0; p <= MR; p++) if (img_sum(m, p) == '0) return p + 1;
    return MR + 1;
  endfunction
  function automatic bit exp_ok(int m);
    return img_sum(m, exp_passes(m) - 1) == '0;
  endfunction
  always @(negedge clk) begin : mdl
    bit nfd, nrd;
    cyc++;
    nfd = 0;
    nrd = 0;
    if (active) begin
      chk("excl_req", longint'(f_req && r_req), 0);
      if (f_req && !prev_freq) rise_cyc = cyc;
      if (be && !prev_err) err_cyc = cyc;
      prev_freq = f_req;
      prev_err  = be;
      if (f_req && !fd && !(hang && rd_n % W == 2)) begin
        chk("flash_addr", fa, SRC + rd_n % W);
        fdat = img(mode, rd_n / W, rd_n % W);
        rd_n++;
        nfd = 1;
        nrd = spur;
      end else if (r_req && !rdn) begin
        chk("ram_addr", ra, DST + wr_n % W);
        chk("ram_data", rdat, img(mode, wr_n / W, wr_n % W));
        chk("wc_at_write", wc, wr_n % W);
        if (ra < W) ram_mem[ra[1:0]] = rdat;
        wr_n++;
        nrd = 1;
        if (spur) begin
          nfd  = 1;
          fdat = 16'hDEAD;
        end
      end
    end else begin
      prev_freq = 0;
      prev_err  = 0;
    end
    fd  = nfd;
    rdn = nrd;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic begin_run(input bit s, input int m, input bit h, input bit sp);
    active = 0;
    rst = 0;
    sel = s;
    tick(2);
    chk("rst_freq", f_req, 0);
    chk("rst_rreq", r_req, 0);
    chk("rst_done", bd, 0);
    chk("rst_err", be, 0);
    chk("rst_code", ec, 0);
    chk("rst_wc", wc, 0);
    chk("rst_faddr", fa, SRC);
    chk("rst_raddr", ra, DST);
    mode = m;
    hang = h;
    spur = sp;
    rd_n = 0;
    wr_n = 0;
    rise_cyc = 0;
    err_cyc = 0;
    for (int i = 0; i < W; i++) ram_mem[i] = '0;
    active = 1;
    rst = 1;
  endtask
  task automatic wait_end(input string nm, input int budget);
    int n = 0;
    while (!(bd || be) && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_finished"}, longint'(bd || be), 1);
  endtask
  task automatic final_check(input string nm, input int m);
    int p = exp_passes(m);
    bit ok = exp_ok(m);
    chk({nm, "_done"}, bd, ok);
    chk({nm, "_err"}, be, !ok);
    chk({nm, "_code"}, ec, ok ? 0 : 3);
    chk({nm, "_reads"}, rd_n, p * W);
    chk({nm, "_wc"}, wc, W);
    for (int i = 0; i < W; i++) chk({nm, "_ram"}, ram_mem[i], img(m, p - 1, i));
    tick(2);
    chk({nm, "_freq_idle"}, f_req, 0);
    chk({nm, "_rreq_idle"}, r_req, 0);
  endtask
  initial begin
    chk("model_passes_m0", exp_passes(0), 1);
    chk("model_passes_m1", exp_passes(1), 3);
    chk("model_passes_m2", exp_passes(2), 2);
    chk("model_ok_m1", exp_ok(1), 0);
    begin_run(0, 0, 0, 0);
    wait_end("t1", 200);
    final_check("t1", 0);
    chk("t1_ram3_lit", ram_mem[3], 16'hFFFA);
    chk("t1_wc_lit", wc, 4);
    start = 1;
    tick();
    start = 0;
    tick(3);
    chk("t1_start_ign_req", f_req, 0);
    chk("t1_start_ign_done", bd, 1);
    begin_run(0, 1, 0, 0);
    wait_end("t2", 300);
    final_check("t2", 1);
    chk("t2_reads_lit", rd_n, 12);
    chk("t2_code_lit", ec, 3);
    begin_run(0, 2, 0, 0);
    wait_end("t3", 300);
    final_check("t3", 2);
    chk("t3_reads_lit", rd_n, 8);
    begin_run(0, 0, 1, 0);
    wait_end("t4", 200);
    chk("t4_err", be, 1);
    chk("t4_done", bd, 0);
    chk("t4_code", ec, 1);
    chk("t4_latency", err_cyc - rise_cyc, TO);
    chk("t4_freq", f_req, 0);
    chk("t4_rreq", r_req, 0);
    chk("t4_reads", rd_n, 2);
    chk("t4_wc", wc, 2);
    begin_run(0, 0, 0, 1);
    wait_end("t5", 300);
    final_check("t5", 0);
    begin_run(0, 0, 0, 0);
    begin
      int n = 0;
      while (wr_n < 2 && n < 100) begin
        tick();
        n++;
      end
      chk("t6_reached_w2", wr_n, 2);
    end
    rst = 0;
    active = 0;
    tick();
    chk("t6_rst_freq", f_req, 0);
    chk("t6_rst_rreq", r_req, 0);
    chk("t6_rst_wc", wc, 0);
    chk("t6_rst_faddr", fa, SRC);
    chk("t6_rst_raddr", ra, DST);
    chk("t6_rst_done", bd, 0);
    begin_run(1, 0, 0, 0);
    tick(5);
    chk("t6b_idle_freq", f_req, 0);
    chk("t6b_idle_wc", wc, 0);
    chk("t6b_idle_done", bd, 0);
    start = 1;
    tick();
    start = 0;
    wait_end("t6b", 200);
    final_check("t6b", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
